// File: rtl/mem_bus_ctrl.sv
// Memory-access stage: turns decoder mem_rd/mem_wr strobes into one req/ack bus transaction.
// Optional bus timeout abort is compiled in with `define MEM_TIMEOUT_EN.
module mem_bus_ctrl #(
   parameter int AW       = 16,
   parameter int DW       = 16,
   parameter int WAIT_CYC = 0,
   parameter int TIMEOUT  = 255
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_mem_rd,
   input  logic          i_mem_wr,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_wdata,
   output logic [DW-1:0] o_rdata,
   output logic          o_stall,
   output logic          o_bus_req,
   output logic          o_bus_we,
   output logic [AW-1:0] o_bus_addr,
   output logic [DW-1:0] o_bus_wdata,
   input  logic          i_bus_ack,
   input  logic [DW-1:0] i_bus_rdata,
   output logic          o_err
);

   // Counter width covers TIMEOUT, which always exceeds WAIT_CYC.
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_wait;
   logic            r_bus_req;
   logic            r_bus_we;
   logic [AW-1:0]   r_bus_addr;
   logic [DW-1:0]   r_bus_wdata;
   logic [DW-1:0]   r_rdata;
   logic            w_start;
   logic            w_ack_ok;
   logic            w_abort;

   assign w_start  = (r_state == IDLE) && (i_mem_rd || i_mem_wr);
   assign w_ack_ok = (r_state == REQ) && i_bus_ack && (r_wait == CW'(WAIT_CYC));

`ifdef MEM_TIMEOUT_EN
   logic [CW-1:0] r_tmo;
   logic          r_err;

   // An honoured ack in the final allowed cycle still wins over the abort.
   assign w_abort = (r_state == REQ) && !w_ack_ok && (r_tmo == CW'(TIMEOUT - 1));
   assign o_err   = r_err;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tmo <= '0;
         r_err <= 1'b0;
      end else begin
         if (r_state == REQ) begin
            r_tmo <= r_tmo + CW'(1);
         end else begin
            r_tmo <= '0;
         end
         if (w_abort) begin
            r_err <= 1'b1;
         end
      end
   end
`else
   assign w_abort = 1'b0;
   assign o_err   = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_state_nxt = REQ;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         REQ: begin
            if (w_ack_ok || w_abort) begin
               w_state_nxt = DONE;
            end else begin
               w_state_nxt = REQ;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_bus_req   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
         r_rdata     <= '0;
         r_wait      <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_bus_req <= (w_state_nxt == REQ);
         if (w_start) begin
            r_bus_addr  <= i_addr;
            r_bus_wdata <= i_wdata;
            r_bus_we    <= i_mem_wr;
         end
         // Wait counter saturates so a held ack is honoured exactly at WAIT_CYC.
         if (r_state == REQ) begin
            if (r_wait != CW'(WAIT_CYC)) begin
               r_wait <= r_wait + CW'(1);
            end
         end else begin
            r_wait <= '0;
         end
         if (w_ack_ok && !r_bus_we) begin
            r_rdata <= i_bus_rdata;
         end else if (w_abort && !r_bus_we) begin
            r_rdata <= '1;
         end
      end
   end

   // Decoder advances on the edge leaving DONE, so DONE itself never stalls.
   assign o_stall     = w_start || (r_state == REQ);
   assign o_bus_req   = r_bus_req;
   assign o_bus_we    = r_bus_we;
   assign o_bus_addr  = r_bus_addr;
   assign o_bus_wdata = r_bus_wdata;
   assign o_rdata     = r_rdata;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: instance 0 has WAIT_CYC=0, instance 1 has WAIT_CYC=2, TIMEOUT=8.
module tb_mem_bus_ctrl;

   logic        clk = 1'b0;
   logic        rst      [2];
   logic        mem_rd   [2];
   logic        mem_wr   [2];
   logic [15:0] a_in     [2];
   logic [15:0] wd_in    [2];
   logic [15:0] rdata    [2];
   logic        stall    [2];
   logic        bus_req  [2];
   logic        bus_we   [2];
   logic [15:0] bus_addr [2];
   logic [15:0] bus_wd   [2];
   logic        ack      [2];
   logic [15:0] brdata   [2];
   logic        err      [2];

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      int          len;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   int nvec  = 0;
   int nfail = 0;

   logic        prev_req [2] = '{1'b0, 1'b0};
   logic        skip     [2] = '{1'b0, 1'b0};
   logic [15:0] cap_addr [2];
   logic [15:0] cap_wd   [2];
   logic        cap_we   [2];
   int          len      [2];

   always #5 clk = ~clk;

   mem_bus_ctrl #(.AW(16), .DW(16), .WAIT_CYC(0), .TIMEOUT(255)) u0 (
      .i_clk(clk), .i_rst(rst[0]), .i_mem_rd(mem_rd[0]), .i_mem_wr(mem_wr[0]),
      .i_addr(a_in[0]), .i_wdata(wd_in[0]), .o_rdata(rdata[0]), .o_stall(stall[0]),
      .o_bus_req(bus_req[0]), .o_bus_we(bus_we[0]), .o_bus_addr(bus_addr[0]),
      .o_bus_wdata(bus_wd[0]), .i_bus_ack(ack[0]), .i_bus_rdata(brdata[0]), .o_err(err[0])
   );

   mem_bus_ctrl #(.AW(16), .DW(16), .WAIT_CYC(2), .TIMEOUT(8)) u1 (
      .i_clk(clk), .i_rst(rst[1]), .i_mem_rd(mem_rd[1]), .i_mem_wr(mem_wr[1]),
      .i_addr(a_in[1]), .i_wdata(wd_in[1]), .o_rdata(rdata[1]), .o_stall(stall[1]),
      .o_bus_req(bus_req[1]), .o_bus_we(bus_we[1]), .o_bus_addr(bus_addr[1]),
      .o_bus_wdata(bus_wd[1]), .i_bus_ack(ack[1]), .i_bus_rdata(brdata[1]), .o_err(err[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: tracks each bus transaction and scores it against the queue when o_bus_req falls.
   always @(negedge clk) begin
      for (int s = 0; s < 2; s++) begin
         if (bus_req[s] && !prev_req[s]) begin
            cap_addr[s] = bus_addr[s];
            cap_wd[s]   = bus_wd[s];
            cap_we[s]   = bus_we[s];
            len[s]      = 1;
         end else if (bus_req[s] && prev_req[s]) begin
            len[s] = len[s] + 1;
            chk("addr_hold", {bus_addr[s], bus_wd[s]}, {cap_addr[s], cap_wd[s]});
         end else if (!bus_req[s] && prev_req[s] && !skip[s]) begin
            exp_t e;
            if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
               chk("unexpected_txn", 32'd1, 32'd0);
            end else begin
               if (s == 0) e = q0.pop_front();
               else        e = q1.pop_front();
               chk("txn_we",    {31'd0, cap_we[s]}, {31'd0, e.we});
               chk("txn_addr",  {16'd0, cap_addr[s]}, {16'd0, e.addr});
               chk("txn_wdata", {16'd0, cap_wd[s]}, {16'd0, e.wdata});
               chk("txn_len",   32'(len[s]), 32'(e.len));
               chk("txn_rdata", {16'd0, rdata[s]}, {16'd0, e.rdata});
            end
         end
         prev_req[s] = bus_req[s];
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Starts from IDLE #1 after an edge; returns #1 after the DONE->IDLE edge with strobes low.
   task automatic txn(input int s, input logic rd, input logic wr,
                      input logic [15:0] addr, input logic [15:0] wdata,
                      input int ack_dly, input logic [15:0] brd,
                      input logic ewe, input logic [15:0] erd, input int elen);
      exp_t e;
      int   k;
      e = '{we: ewe, addr: addr, wdata: wdata, rdata: erd, len: elen};
      if (s == 0) q0.push_back(e);
      else        q1.push_back(e);
      mem_rd[s] = rd;
      mem_wr[s] = wr;
      a_in[s]   = addr;
      wd_in[s]  = wdata;
      #1;
      chk("stall_accept", {31'd0, stall[s]}, 32'd1);
      cyc();
      chk("stall_req", {31'd0, stall[s]}, 32'd1);
      a_in[s]  = ~addr;
      wd_in[s] = ~wdata;
      k = 0;
      while (bus_req[s] && k < 40) begin
         ack[s]    = (k >= ack_dly);
         brdata[s] = brd;
         cyc();
         k++;
      end
      chk("req_drop", {31'd0, bus_req[s]}, 32'd0);
      ack[s] = 1'b0;
      #1;
      chk("stall_done", {31'd0, stall[s]}, 32'd0);
      @(posedge clk);
      #1;
      mem_rd[s] = 1'b0;
      mem_wr[s] = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int s = 0; s < 2; s++) begin
         rst[s] = 1'b1; mem_rd[s] = 1'b0; mem_wr[s] = 1'b0; a_in[s] = 16'h0000;
         wd_in[s] = 16'h0000; ack[s] = 1'b0; brdata[s] = 16'h0000;
      end
      cyc(); cyc();
      rst[0] = 1'b0; rst[1] = 1'b0;
      #1;
      for (int s = 0; s < 2; s++) begin
         chk("rst_req",   {31'd0, bus_req[s]}, 32'd0);
         chk("rst_we",    {31'd0, bus_we[s]}, 32'd0);
         chk("rst_addr",  {16'd0, bus_addr[s]}, 32'd0);
         chk("rst_wdata", {16'd0, bus_wd[s]}, 32'd0);
         chk("rst_rdata", {16'd0, rdata[s]}, 32'd0);
         chk("rst_err",   {31'd0, err[s]}, 32'd0);
         chk("rst_stall", {31'd0, stall[s]}, 32'd0);
      end
      cyc();

      // Reset in the middle of a REQ with o_rdata = 0x1234.
      txn(0, 1'b1, 1'b0, 16'h0050, 16'h0000, 0, 16'h1234, 1'b0, 16'h1234, 1);
      mem_rd[0] = 1'b1; a_in[0] = 16'h0060;
      cyc();
      chk("mid_req", {31'd0, bus_req[0]}, 32'd1);
      skip[0] = 1'b1; rst[0] = 1'b1; mem_rd[0] = 1'b0;
      cyc();
      rst[0] = 1'b0;
      chk("mid_rst_req",   {31'd0, bus_req[0]}, 32'd0);
      chk("mid_rst_rdata", {16'd0, rdata[0]}, 32'h0000);
      chk("mid_rst_err",   {31'd0, err[0]}, 32'd0);
      chk("mid_rst_stall", {31'd0, stall[0]}, 32'd0);
      ack[0] = 1'b1; brdata[0] = 16'h9999;
      cyc(); cyc();
      ack[0] = 1'b0;
      chk("late_ack_rdata", {16'd0, rdata[0]}, 32'h0000);
      chk("late_ack_req",   {31'd0, bus_req[0]}, 32'd0);
      skip[0] = 1'b0;
      cyc();

      // Minimum-latency read, both strobes, back-to-back reads.
      txn(0, 1'b1, 1'b0, 16'h0100, 16'h0000, 0, 16'hBEEF, 1'b0, 16'hBEEF, 1);
      cyc();
      txn(0, 1'b1, 1'b1, 16'h0200, 16'hA5C3, 0, 16'h0BAD, 1'b1, 16'hBEEF, 1);
      cyc();
      txn(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 0, 16'h1111, 1'b0, 16'h1111, 1);
      txn(0, 1'b1, 1'b0, 16'h0011, 16'h0000, 0, 16'h2222, 1'b0, 16'h2222, 1);
      chk("b2b_rdata", {16'd0, rdata[0]}, 32'h2222);

      // WAIT_CYC=2: held ack honoured in the 3rd REQ cycle; late ack adds cycles.
      txn(1, 1'b0, 1'b1, 16'h8000, 16'h5A5A, 0, 16'hDEAD, 1'b1, 16'h0000, 3);
      cyc();
      txn(1, 1'b1, 1'b0, 16'h0123, 16'h0000, 3, 16'h7777, 1'b0, 16'h7777, 4);
      cyc();

`ifdef MEM_TIMEOUT_EN
      txn(1, 1'b1, 1'b0, 16'h0C00, 16'h0000, 100, 16'h0000, 1'b0, 16'hFFFF, 8);
      chk("tmo_err", {31'd0, err[1]}, 32'd1);
      cyc(); cyc(); cyc();
      chk("tmo_err_sticky", {31'd0, err[1]}, 32'd1);
      txn(1, 1'b1, 1'b0, 16'h0124, 16'h0000, 0, 16'h3333, 1'b0, 16'h3333, 3);
      chk("tmo_err_after_txn", {31'd0, err[1]}, 32'd1);
      rst[1] = 1'b1;
      cyc();
      rst[1] = 1'b0;
      chk("tmo_err_rst", {31'd0, err[1]}, 32'd0);
`else
      mem_rd[1] = 1'b1; a_in[1] = 16'h0C00;
      cyc();
      repeat (12) cyc();
      chk("no_tmo_req", {31'd0, bus_req[1]}, 32'd1);
      chk("no_tmo_err", {31'd0, err[1]}, 32'd0);
      skip[1] = 1'b1; rst[1] = 1'b1; mem_rd[1] = 1'b0;
      cyc();
      rst[1] = 1'b0;
      chk("no_tmo_rst_req", {31'd0, bus_req[1]}, 32'd0);
      cyc();
      skip[1] = 1'b0;
`endif

      repeat (5) cyc();
      chk("q0_empty", 32'(q0.size()), 32'd0);
      chk("q1_empty", 32'(q1.size()), 32'd0);
      chk("idle_req0", {31'd0, bus_req[0]}, 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Memory-access stage directly downstream of the instruction decoder.
- Consumes the decoder's per-cycle `mem_rd`/`mem_wr` strobes and runs a req/ack transaction on the external memory bus.
- Holds the decoder FSM via a stall output until the transaction completes.
- Latches read data into a memory data register, which the datapath uses as the R_MEM source.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- WAIT_CYC, 0, minimum cycles `o_bus_req` is held before `i_bus_ack` is honoured (0..15).
- TIMEOUT, 255, REQ cycles before abort; used only with MEM_TIMEOUT_EN; must exceed WAIT_CYC.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_mem_rd  in  1  read request from decoder (level, held while stalled).
- i_mem_wr  in  1  write request from decoder (level, held while stalled).
- i_addr  in  AW  access address.
- i_wdata  in  DW  write data (ALU result bus).
- o_rdata  out  DW  memory data register (R_MEM source).
- o_stall  out  1  freezes decoder state register and IP update.
- o_bus_req  out  1  bus request.
- o_bus_we  out  1  1 = write, 0 = read; valid while o_bus_req.
- o_bus_addr  out  AW  latched address.
- o_bus_wdata  out  DW  latched write data.
- i_bus_ack  in  1  bus completion, one or more cycles.
- i_bus_rdata  in  DW  read data, valid with i_bus_ack.
- o_err  out  1  sticky bus timeout flag.

Behaviour:
- Reset is synchronous: when i_rst is high at an edge:
  - state goes to IDLE;
  - o_bus_req=0, o_bus_we=0;
  - o_bus_addr=0, o_bus_wdata=0, o_rdata=0;
  - o_err=0, wait/timeout counters=0.
- Reset mid-transaction drops o_bus_req on the next edge. A late ack is ignored.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If i_mem_rd or i_mem_wr:
    - latch i_addr and i_wdata;
    - set o_bus_we = i_mem_wr;
    - go to REQ;
    - assert o_bus_req from the next cycle.
  - If both strobes are high, write wins.
- REQ:
  - o_bus_req=1.
  - The wait counter counts up from 0 each cycle, saturating at WAIT_CYC.
  - i_bus_ack is honoured only when the counter equals WAIT_CYC.
  - On an honoured ack:
    - if a read, o_rdata <= i_bus_rdata;
    - deassert o_bus_req on the next edge;
    - go to DONE.
  - An ack before the wait count is reached is ignored. The transaction continues.
- DONE: o_bus_req=0, then unconditional return to IDLE. The request strobes seen in DONE are ignored; they are the same instruction's.
- o_stall is combinational:
  - 1 when (IDLE and (i_mem_rd|i_mem_wr)) or REQ;
  - 0 in DONE, so the decoder advances on the edge leaving DONE.
- Latency:
  - minimum access with WAIT_CYC=0 and ack in the first REQ cycle = 3 cycles (IDLE-accept, REQ, DONE);
  - each extra ack delay adds 1 cycle.
- i_bus_ack in IDLE or DONE is ignored.
- Back-to-back: a new request in the cycle after DONE is accepted normally from IDLE.
- o_rdata:
  - changes only on a completed read;
  - unchanged by writes, reset-free otherwise;
  - holds indefinitely.
- o_bus_addr and o_bus_wdata stay stable for the entire REQ period, regardless of input changes.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With MEM_TIMEOUT_EN defined:
  - a REQ-cycle counter increments each REQ cycle and clears in IDLE;
  - on reaching TIMEOUT with no honoured ack, the transaction aborts: o_bus_req drops, state goes to DONE, o_err=1 (sticky until reset);
  - an aborted read loads o_rdata=all-ones;
  - an aborted write has no further effect.
- Without MEM_TIMEOUT_EN:
  - REQ waits indefinitely;
  - o_err is tied to 0;
  - no timeout counter is synthesised.

Test Plan:
- Reset with o_rdata previously 0x1234 and the FSM in REQ, i_rst=1 for one edge:
  - o_bus_req=0, o_rdata=0x0000, o_err=0, o_stall=0 next cycle;
  - a late ack does not change o_rdata.
- Read, WAIT_CYC=0, i_addr=0x0100, ack with rdata=0xBEEF in the first REQ cycle:
  - o_bus_req high exactly 1 cycle, o_bus_we=0;
  - o_rdata=0xBEEF after DONE;
  - o_stall high 2 cycles, then low.
- Write, WAIT_CYC=2, addr=0x8000, wdata=0x5A5A, ack held high from the first REQ cycle:
  - ack is honoured in the 3rd REQ cycle;
  - o_bus_wdata=0x5A5A throughout;
  - o_rdata unchanged.
- i_mem_rd and i_mem_wr both high:
  - o_bus_we=1 (write performed);
  - only one bus transaction is issued even though the strobes stay high through DONE.
- Two back-to-back reads (0x0010→0x1111, 0x0011→0x2222): two separate transactions, o_rdata sequence 0x1111 then 0x2222.
- With MEM_TIMEOUT_EN, TIMEOUT=8, read, never ack:
  - abort after 8 REQ cycles;
  - o_err=1 and stays 1, o_rdata=0xFFFF;
  - o_err clears only on i_rst.
